score_arbiter: RTL and testbench

Round-robin arbiter that shares one ScoreTracker instance between `N_REQ` game stations. Each station raises a request carrying a score, player ID and guest flag. The arbiter grants one station at a time and issues a single `score_req` pulse to the tracker. It waits for the tracker's `valid`, or gives up after a timeout, and returns the winner flags to the granted station with a one-cycle `done` strobe.

---
 rtl/score_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_score_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_arbiter.sv
// -----------------------------------------------------------------------------
// score_arbiter
//
// Round-robin arbiter that lets N_REQ game stations share one ScoreTracker.
// A station is granted, its operands are latched, one score_req pulse goes to
// the tracker, and the arbiter waits for the tracker's valid. If valid does not
// arrive within TIMEOUT cycles the arbiter gives up. Either way the result is
// captured and the granted station receives a one-cycle done strobe.
//
// Parameters
//   N_REQ    number of stations (2..8)
//   TIMEOUT  maximum cycles spent waiting for valid (1..255)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[N_REQ]        per-station request level, held until that station's done
//   req_score         7 bits per station, station i in [7i+6:7i]
//   req_pid           3 bits per station, station i in [3i+2:3i]
//   req_guest         1 bit per station
//   grant[N_REQ]      one-hot owner of the current transaction, 0 when idle
//   done[N_REQ]       one-hot, one-cycle completion strobe
//   res_personal      personal_winner of the last completed transaction
//   res_global        global_winner of the last completed transaction
//   res_timeout       last transaction ended without valid
//   busy              a transaction is in progress
//   score_req         one-cycle request pulse to the tracker
//   score, playerID,
//   isGuest           latched operands of the granted station
//   personal_winner,
//   global_winner,
//   valid             tracker result and its qualifier
// -----------------------------------------------------------------------------
module score_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [7*N_REQ-1:0] req_score,
  input  logic [3*N_REQ-1:0] req_pid,
  input  logic [N_REQ-1:0]   req_guest,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               res_personal,
  output logic               res_global,
  output logic               res_timeout,
  output logic               busy,
  output logic               score_req,
  output logic [6:0]         score,
  output logic [2:0]         playerID,
  output logic               isGuest,
  input  logic               personal_winner,
  input  logic               global_winner,
  input  logic               valid
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [6:0]       pick_score;
  logic [2:0]       pick_pid;
  logic             pick_guest;

  // Round-robin pick. The first pass takes the lowest requester at or above
  // rr_ptr; only when there is none does the second pass wrap around and take
  // the lowest requester overall.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[i] && (IDX_W'(i) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[i]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  // Operand mux for the picked station.
  always_comb begin
    pick_score = '0;
    pick_pid   = '0;
    pick_guest = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_score = req_score[7*i +: 7];
        pick_pid   = req_pid[3*i +: 3];
        pick_guest = req_guest[i];
      end
    end
  end

  assign timed_out = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // register samples the values from before this clock edge.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_found) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      // valid takes priority over the timeout on the last allowed cycle.
      S_WAIT:  if (valid || timed_out) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath. The operand registers are held through IDLE and are cleared
  // only by reset. A reset in mid-transaction drops it without a done, which
  // leaves the station's req up, so it is arbitrated again from station 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      wait_cnt     <= '0;
      score        <= '0;
      playerID     <= '0;
      isGuest      <= 1'b0;
      res_personal <= 1'b0;
      res_global   <= 1'b0;
      res_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            gnt_idx  <= pick_idx;
            score    <= pick_score;
            playerID <= pick_pid;
            isGuest  <= pick_guest;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (valid) begin
            res_personal <= personal_winner;
            res_global   <= global_winner;
            res_timeout  <= 1'b0;
          end else if (timed_out) begin
            res_personal <= 1'b0;
            res_global   <= 1'b0;
            res_timeout  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        // The station just served becomes lowest priority.
        S_RESP: rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign score_req = (state == S_ISSUE);
  assign grant     = busy ? (N_REQ'(1) << gnt_idx) : '0;
  assign done      = (state == S_RESP) ? grant : '0;

endmodule

// File: tb/tb_score_arbiter.sv
// -----------------------------------------------------------------------------
// tb_score_arbiter
//
// Self-checking bench for score_arbiter (N_REQ=4, TIMEOUT=15). It runs a table
// of single-transaction vectors, hand-written sequences for contention, stray
// valid, reset in WAIT and operand change, and a randomized run checked against
// a transaction-level round-robin model.
// -----------------------------------------------------------------------------
module tb_score_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  typedef struct {
    logic [N-1:0] req_v;
    int           stn;        // station whose operands are given below
    logic [6:0]   sc;
    logic [2:0]   pid;
    logic         gst;
    int           k;          // WAIT cycle index carrying valid, -1 = never
    logic         pw;
    logic         gw;
    logic [N-1:0] exp_grant;
    int           exp_lat;    // request cycle to done cycle
    logic         exp_p;
    logic         exp_g;
    logic         exp_t;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_score;
  logic [3*N-1:0] req_pid;
  logic [N-1:0]   req_guest;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           res_personal;
  logic           res_global;
  logic           res_timeout;
  logic           busy;
  logic           score_req;
  logic [6:0]     score;
  logic [2:0]     playerID;
  logic           isGuest;
  logic           personal_winner;
  logic           global_winner;
  logic           valid;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[6];

  always #5 clk = ~clk;

  score_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_score       (req_score),
    .req_pid         (req_pid),
    .req_guest       (req_guest),
    .grant           (grant),
    .done            (done),
    .res_personal    (res_personal),
    .res_global      (res_global),
    .res_timeout     (res_timeout),
    .busy            (busy),
    .score_req       (score_req),
    .score           (score),
    .playerID        (playerID),
    .isGuest         (isGuest),
    .personal_winner (personal_winner),
    .global_winner   (global_winner),
    .valid           (valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [6:0] s, input logic [2:0] p, input logic g);
    req_score[7*i +: 7] = s;
    req_pid[3*i +: 3]   = p;
    req_guest[i]        = g;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    valid = 1'b0;
    step();
    rst   = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int           lat;
    int           n_issue;
    logic [N-1:0] iss_grant;
    logic [N-1:0] done_v;
    logic [6:0]   iss_score;
    logic [2:0]   iss_pid;
    logic         iss_g;
    logic [2:0]   res_v;
    logic [6:0]   done_score;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 7'(i * 13 + 3), 3'(i + 1), 1'(i & 1));
    set_op(v.stn, v.sc, v.pid, v.gst);
    personal_winner = v.pw;
    global_winner   = v.gw;
    req        = v.req_v;
    lat        = -1;
    n_issue    = 0;
    iss_grant  = '0;
    iss_score  = 'x;
    iss_pid    = 'x;
    iss_g      = 1'bx;
    done_v     = '0;
    res_v      = 'x;
    done_score = 'x;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (score_req) begin
        n_issue++;
        iss_grant = grant;
        iss_score = score;
        iss_pid   = playerID;
        iss_g     = isGuest;
      end
      if (done != '0) begin
        lat        = cyc;
        done_v     = done;
        res_v      = {res_personal, res_global, res_timeout};
        done_score = score;
        break;
      end
      valid = (v.k >= 0) && (cyc == v.k + 2);
      step();
    end
    valid = 1'b0;
    req   = '0;
    step();
    check($sformatf("vec%0d latency", id), 32'(lat), 32'(v.exp_lat));
    check($sformatf("vec%0d done", id), 32'(done_v), 32'(v.exp_grant));
    check($sformatf("vec%0d issue_count", id), 32'(n_issue), 32'd1);
    check($sformatf("vec%0d issue_grant", id), 32'(iss_grant), 32'(v.exp_grant));
    check($sformatf("vec%0d score", id), 32'(iss_score), 32'(v.sc));
    check($sformatf("vec%0d playerID", id), 32'(iss_pid), 32'(v.pid));
    check($sformatf("vec%0d isGuest", id), 32'(iss_g), 32'(v.gst));
    check($sformatf("vec%0d results", id), 32'(res_v), 32'({v.exp_p, v.exp_g, v.exp_t}));
    check($sformatf("vec%0d score_at_done", id), 32'(done_score), 32'(v.sc));
    check($sformatf("vec%0d idle_after", id), 32'({busy, grant}), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int           order[8];
  int           n_done;
  int           rearm[N];
  int           ptr;
  int           w;
  int           k;
  int           nwait;
  logic         pwx;
  logic         gwx;
  logic [N-1:0] eg;
  logic [6:0]   exp_sc;
  logic [2:0]   exp_pid;
  logic         exp_g;
  logic [2:0]   exp_res;
  logic [2:0]   prev_res;

  initial begin
    rst = 1'b1;
    req = '0;
    req_score = '0;
    req_pid = '0;
    req_guest = '0;
    valid = 1'b0;
    personal_winner = 1'b0;
    global_winner = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset outputs", 32'({grant, done, res_personal, res_global, res_timeout, busy,
                                score_req, score, playerID, isGuest}), 32'd0);

    // ---------------- table-driven single transactions ----------------
    vecs[0] = '{4'b0100, 2, 7'd93,  3'd5, 1'b0,  2, 1'b1, 1'b0, 4'b0100,  5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'b1010, 1, 7'd40,  3'd3, 1'b1,  0, 1'b0, 1'b1, 4'b0010,  3, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b1000, 3, 7'd127, 3'd7, 1'b1, -1, 1'b1, 1'b1, 4'b1000, 17, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'b0001, 0, 7'd64,  3'd2, 1'b1, 14, 1'b1, 1'b1, 4'b0001, 17, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{4'b1111, 0, 7'd17,  3'd6, 1'b0,  1, 1'b1, 1'b0, 4'b0001,  4, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b0110, 1, 7'd99,  3'd4, 1'b0, 13, 1'b0, 1'b0, 4'b0010, 16, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ---------------- contention: all four, re-raise 2 cycles after done ----------------
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_op(i, 7'(10 + i), 3'(i), 1'b0);
      rearm[i] = 0;
    end
    valid = 1'b1;
    personal_winner = 1'b1;
    global_winner = 1'b0;
    req = '1;
    n_done = 0;
    for (int c = 0; c < 80 && n_done < 8; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (rearm[i] > 0) begin
          rearm[i]--;
          if (rearm[i] == 0) req[i] = 1'b1;
        end
      end
      if (done != '0) begin
        order[n_done] = onehot_idx(done);
        n_done++;
        for (int i = 0; i < N; i++) begin
          if (done[i]) begin
            req[i]   = 1'b0;
            rearm[i] = 2;
          end
        end
      end
    end
    req = '0;
    valid = 1'b0;
    step();
    check("contention done_count", 32'(n_done), 32'd8);
    for (int i = 0; i < n_done; i++)
      check($sformatf("contention grant_order[%0d]", i), 32'(order[i]), 32'(i % N));

    // ---------------- stray valid in IDLE and ISSUE ----------------
    do_reset();
    set_op(3, 7'd77, 3'd2, 1'b1);
    valid = 1'b1;
    personal_winner = 1'b1;
    global_winner = 1'b1;
    step();
    check("stray idle", 32'({busy, done, grant}), 32'd0);
    valid = 1'b0;
    req = 4'b1000;
    step();
    check("stray issue", 32'({busy, score_req, grant}), 32'({1'b1, 1'b1, 4'b1000}));
    valid = 1'b1;
    step();
    check("stray wait0", 32'({busy, score_req, done, res_personal, res_global, res_timeout}),
          32'({1'b1, 1'b0, 4'b0000, 3'b000}));
    valid = 1'b0;
    step();
    check("stray wait1", 32'({busy, done}), 32'({1'b1, 4'b0000}));
    valid = 1'b1;
    personal_winner = 1'b0;
    global_winner = 1'b1;
    step();
    check("stray resp done", 32'(done), 32'(4'b1000));
    check("stray resp results", 32'({res_personal, res_global, res_timeout}), 32'(3'b010));
    check("stray resp operands", 32'({score, playerID, isGuest}), 32'({7'd77, 3'd2, 1'b1}));
    valid = 1'b0;
    req = '0;
    step();

    // ---------------- reset during WAIT ----------------
    do_reset();
    set_op(0, 7'd55, 3'd1, 1'b1);
    set_op(2, 7'd88, 3'd6, 1'b0);
    req = 4'b0001;
    valid = 1'b1;
    personal_winner = 1'b1;
    global_winner = 1'b1;
    step();
    step();
    step();
    check("rstwait first done", 32'(done), 32'(4'b0001));
    req = 4'b0101;
    valid = 1'b0;
    step();
    check("rstwait idle results", 32'({busy, res_personal, res_global, res_timeout}),
          32'({1'b0, 3'b110}));
    step();
    check("rstwait grant before reset", 32'({grant, score}), 32'({4'b0100, 7'd88}));
    step();
    rst = 1'b1;
    step();
    check("rstwait grant/done zero", 32'({grant, done}), 32'd0);
    check("rstwait res zero", 32'({res_personal, res_global, res_timeout}), 32'd0);
    check("rstwait ctl zero", 32'({busy, score_req}), 32'd0);
    check("rstwait operands zero", 32'({score, playerID, isGuest}), 32'd0);
    rst = 1'b0;
    step();
    check("rstwait regrant", 32'({score_req, grant, score}), 32'({1'b1, 4'b0001, 7'd55}));
    valid = 1'b1;
    step();
    step();
    check("rstwait regrant done", 32'(done), 32'(4'b0001));
    req = '0;
    valid = 1'b0;
    step();

    // ---------------- operand change and request drop during WAIT ----------------
    do_reset();
    set_op(1, 7'd40, 3'd2, 1'b0);
    req = 4'b0010;
    step();
    check("opchg issue score", 32'(score), 32'd40);
    step();
    set_op(1, 7'd100, 3'd7, 1'b1);
    req = '0;
    step();
    check("opchg wait", 32'({busy, grant, score}), 32'({1'b1, 4'b0010, 7'd40}));
    valid = 1'b1;
    personal_winner = 1'b0;
    global_winner = 1'b1;
    step();
    check("opchg done", 32'({done, score}), 32'({4'b0010, 7'd40}));
    valid = 1'b0;
    step();
    check("opchg idle hold", 32'({busy, score, playerID}), 32'({1'b0, 7'd40, 3'd2}));

    // ---------------- randomized run vs transaction-level model ----------------
    do_reset();
    ptr = 0;
    prev_res = 3'b000;
    for (int t = 0; t < 60; t++) begin
      // IDLE cycle: stations may raise requests and change operands freely.
      check("rnd idle ctl", 32'({busy, score_req, grant, done}), 32'd0);
      check("rnd idle results", 32'({res_personal, res_global, res_timeout}), 32'(prev_res));
      for (int i = 0; i < N; i++) begin
        set_op(i, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
      if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
      valid = 1'($urandom_range(0, 1));
      personal_winner = 1'($urandom_range(0, 1));
      global_winner = 1'($urandom_range(0, 1));
      w = -1;
      for (int off = 0; off < N; off++)
        if (w < 0 && req[(ptr + off) % N]) w = (ptr + off) % N;
      eg = '0;
      eg[w] = 1'b1;
      exp_sc  = req_score[7*w +: 7];
      exp_pid = req_pid[3*w +: 3];
      exp_g   = req_guest[w];
      k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      pwx = 1'($urandom_range(0, 1));
      gwx = 1'($urandom_range(0, 1));
      exp_res = (k >= 0) ? {pwx, gwx, 1'b0} : 3'b001;
      step();
      // ISSUE
      check("rnd issue ctl", 32'({busy, score_req, grant, done}), 32'({1'b1, 1'b1, eg, 4'b0000}));
      check("rnd issue ops", 32'({score, playerID, isGuest}), 32'({exp_sc, exp_pid, exp_g}));
      for (int i = 0; i < N; i++)
        set_op(i, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
      valid = 1'($urandom_range(0, 1));
      nwait = (k >= 0) ? k + 1 : TO;
      for (int j = 0; j < nwait; j++) begin
        step();
        check("rnd wait ctl", 32'({busy, score_req, grant, done}), 32'({1'b1, 1'b0, eg, 4'b0000}));
        check("rnd wait ops", 32'({score, playerID, isGuest}), 32'({exp_sc, exp_pid, exp_g}));
        valid = (j == k);
        personal_winner = (j == k) ? pwx : 1'($urandom_range(0, 1));
        global_winner   = (j == k) ? gwx : 1'($urandom_range(0, 1));
        set_op(w, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 7) == 0) req[w] = 1'b0;
      end
      step();
      // RESP
      check("rnd resp ctl", 32'({busy, score_req, grant, done}), 32'({1'b1, 1'b0, eg, eg}));
      check("rnd resp results", 32'({res_personal, res_global, res_timeout}), 32'(exp_res));
      check("rnd resp ops", 32'({score, playerID, isGuest}), 32'({exp_sc, exp_pid, exp_g}));
      valid = 1'($urandom_range(0, 1));
      personal_winner = 1'($urandom_range(0, 1));
      global_winner = 1'($urandom_range(0, 1));
      req[w] = ($urandom_range(0, 2) == 0);
      ptr = (w + 1) % N;
      prev_res = exp_res;
      step();
    end
    req = '0;
    valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
